alu_nibble_seq: RTL and testbench

- Sequencing controller that performs WIDTH-bit add/subtract by stepping a shared 4-bit adder datapath across the operand one nibble per cycle, LSB first.
- Chains the carry between nibbles through a register.
- Sits between a requester using a start/done handshake and a nibble adder sub-module.
- Produces the final result plus OF/CF/ZF/SF/PF flags with the same semantics the team's 4-bit ALU uses.

---
 rtl/alu_pkg.sv | 15 +
 rtl/nibble_add.sv | 29 ++
 rtl/alu_nibble_seq.sv | 150 +++++++++++++++
 tb/tb_alu_nibble_seq.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and state encoding for the nibble-serial ALU
package alu_pkg;

  localparam int NIB_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add.sv
// rtl/nibble_add.sv - combinational 4-bit ripple adder exposing carry into and out of the top bit
module nibble_add
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             c3,
  output logic             c4
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  // c3 feeds the signed-overflow flag of the most significant nibble.
  assign c3 = c[NIB_W-1];
  assign c4 = c[NIB_W];

endmodule

// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - WIDTH-bit add/subtract sequenced one nibble per cycle over a shared adder
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     op,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] result,
  output logic                     of,
  output logic                     cf,
  output logic                     zf,
  output logic                     sf,
  output logic                     pf
);

  localparam int WIDTH = NIB_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               of_q, of_d;
  logic               cf_q, cf_d;
  logic               zf_q, zf_d;
  logic               sf_q, sf_d;
  logic               pf_q, pf_d;

  logic [NIB_W-1:0]   nib_a;
  logic [NIB_W-1:0]   nib_b;
  logic [NIB_W-1:0]   nib_s;
  logic               nib_c3;
  logic               nib_c4;

  // Subtraction is A + ~B + 1: B is inverted here and the +1 enters as the initial carry.
  assign nib_a = a_q[NIB_W*idx_q +: NIB_W];
  assign nib_b = b_q[NIB_W*idx_q +: NIB_W] ^ {NIB_W{op_q}};

  nibble_add u_nibble_add (
    .a   (nib_a),
    .b   (nib_b),
    .cin (carry_q),
    .s   (nib_s),
    .c3  (nib_c3),
    .c4  (nib_c4)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    of_d     = of_q;
    cf_d     = cf_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    pf_d     = pf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          carry_d = op;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        result_d[NIB_W*idx_q +: NIB_W] = nib_s;
        carry_d = nib_c4;
        if (idx_q == IDX_LAST) begin
          // Flags come from the completed result and the top nibble's carries.
          cf_d    = nib_c4 ^ op_q;
          of_d    = nib_c4 ^ nib_c3;
          sf_d    = result_d[WIDTH-1];
          zf_d    = ~|result_d;
          pf_d    = ^result_d;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      of_q     <= 1'b0;
      cf_q     <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      pf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      of_q     <= of_d;
      cf_q     <= cf_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      pf_q     <= pf_d;
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;
  assign of     = of_q;
  assign cf     = cf_q;
  assign zf     = zf_q;
  assign sf     = sf_q;
  assign pf     = pf_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// tb/tb_alu_nibble_seq.sv - self-checking bench for alu_nibble_seq against an arithmetic reference model
module tb_alu_nibble_seq;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         of, cf, zf, sf, pf;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .of     (of),
    .cf     (cf),
    .zf     (zf),
    .sf     (sf),
    .pf     (pf)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] r;
    logic         of;
    logic         cf;
    logic         zf;
    logic         sf;
    logic         pf;
  } res_t;

  // Plain two's-complement arithmetic; borrow is unsigned a<b, overflow from operand/result signs.
  function automatic res_t ref_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    res_t       t;
    logic [W:0] full;
    if (!o) begin
      full = {1'b0, x} + {1'b0, y};
      t.r  = full[W-1:0];
      t.cf = full[W];
      t.of = (x[W-1] == y[W-1]) && (t.r[W-1] != x[W-1]);
    end else begin
      t.r  = x - y;
      t.cf = (x < y);
      t.of = (x[W-1] != y[W-1]) && (t.r[W-1] != x[W-1]);
    end
    t.zf = (t.r == '0);
    t.sf = t.r[W-1];
    t.pf = ^t.r;
    return t;
  endfunction

  function automatic logic [W-1:0] flags_of(input res_t t);
    return W'({t.of, t.cf, t.zf, t.sf, t.pf});
  endfunction

  // Model: a request occupies NIBBLES busy cycles, then one done cycle; start only matters when idle.
  int   m_left = 0;
  logic m_done = 1'b0;
  res_t m_exp  = '0;
  res_t m_pend = '0;
  logic chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_exp  = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_exp  = m_pend;
      end
    end else if (start) begin
      m_left = NIBBLES;
      m_pend = ref_op(op, a, b);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", W'(busy), W'(m_left > 0));
      check("cyc_done", W'(done), W'(m_done));
      if (m_left == 0) begin
        check("cyc_result", result, m_exp.r);
        check("cyc_flags", W'({of, cf, zf, sf, pf}), flags_of(m_exp));
      end
    end
  end

  task automatic run_op(input string nm, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic [4:0] ef);
    int k;
    int nbusy;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    op    = 1'($urandom);
    k     = 1;
    nbusy = busy ? 1 : 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
      if (busy) nbusy++;
    end
    check({nm, "_latency"}, W'(k), W'(5));
    check({nm, "_busycycles"}, W'(nbusy), W'(4));
    check({nm, "_result"}, result, er);
    check({nm, "_flags"}, W'({of, cf, zf, sf, pf}), W'(ef));
    @(negedge clk);
  endtask

  res_t pin;
  int   ndone;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;

    pin = ref_op(1'b0, 16'h1234, 16'h0F0F);
    check("pin_add_result", pin.r, 16'h2143);
    check("pin_add_flags", flags_of(pin), W'(5'b00001));
    pin = ref_op(1'b1, 16'h8000, 16'h0001);
    check("pin_sub_flags", flags_of(pin), W'(5'b10001));

    @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_result", result, 16'h0000);
    check("reset_flags", W'({of, cf, zf, sf, pf}), W'(0));
    rst = 1'b0;
    @(negedge clk);

    // flags literal order: {of, cf, zf, sf, pf}
    run_op("add_1234_0f0f", 1'b0, 16'h1234, 16'h0F0F, 16'h2143, 5'b00001);
    run_op("sub_0_1",       1'b1, 16'h0000, 16'h0001, 16'hFFFF, 5'b01010);
    run_op("add_7fff_1",    1'b0, 16'h7FFF, 16'h0001, 16'h8000, 5'b10011);
    run_op("add_ffff_1",    1'b0, 16'hFFFF, 16'h0001, 16'h0000, 5'b01100);
    run_op("sub_equal",     1'b1, 16'h1234, 16'h1234, 16'h0000, 5'b00100);
    run_op("sub_8000_1",    1'b1, 16'h8000, 16'h0001, 16'h7FFF, 5'b10001);

    // start pulsed during RUN must be dropped
    start = 1'b1; op = 1'b0; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("ignore_done_count", W'(ndone), W'(1));
    check("ignore_result", result, 16'h0002);

    // reset during the second RUN cycle aborts silently
    start = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h2222;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_result", result, 16'h0000);
    check("abort_flags", W'({of, cf, zf, sf, pf}), W'(0));
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", W'(ndone), W'(0));
    run_op("add_after_abort", 1'b0, 16'h0003, 16'h0004, 16'h0007, 5'b00001);

    // randomized traffic with corner operands, stray starts and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 2) == 0);
      op    = 1'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 16'h0000;
        1:       a = 16'hFFFF;
        2:       a = 16'h7FFF;
        3:       a = 16'h8000;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       b = 16'h0000;
        1:       b = 16'hFFFF;
        2:       b = 16'h0001;
        3:       b = 16'h8000;
        default: b = W'($urandom);
      endcase
      @(negedge clk);
    end
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
